sighash_stream_hasher: RTL and testbench

Sequential SHA-256 / double-SHA-256 engine for BIP143 sighash and intermediate-hash computation. Accepts a message of run-time byte length as a stream of 32-bit words, applies SHA-256 padding internally, and iterates a single compression datapath over as many 512-bit blocks as the length requires. An optional second pass produces SHA256d. It replaces per-layout unrolled compression chains with one reusable, area-bounded hasher shared by the prevouts, outputs and full-preimage hashing steps.

---
 rtl/sighash_stream_hasher_pkg.sv | 59 +++++
 rtl/sighash_stream_hasher_if.sv | 23 ++
 rtl/sighash_stream_hasher_round_core.sv | 39 +++
 rtl/sighash_stream_hasher.sv | 194 +++++++++++++++++++
 tb/tb_sighash_stream_hasher.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sighash_stream_hasher_pkg.sv
// SHA-256 constants, round helper functions and the engine state encoding
// shared by the streaming hasher and its round core.
package sighash_stream_hasher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPRESS,
    S_FEED,
    S_SECOND,
    S_DONE
  } state_t;

  // Index 0 holds the first initial hash word (a / H0).
  localparam logic [7:0][31:0] H0 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sighash_stream_hasher_if.sv
// Job/stream/digest handshake bundle between a hash client (master) and the engine (slave).
interface sighash_stream_hasher_if #(parameter int LEN_W = 16) ();
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             dbl;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [255:0]     out_digest;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, msg_len, dbl, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_digest, busy
  );

  modport slave (
    input  start, msg_len, dbl, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_digest, busy
  );
endinterface

// File: rtl/sighash_stream_hasher_round_core.sv
// Combinational SHA-256 compression slice: applies RPC consecutive rounds to {a..h}.
module sighash_stream_hasher_round_core #(
  parameter int RPC = 1
) (
  input  logic [7:0][31:0]     st_in,
  input  logic [RPC-1:0][31:0] w_in,
  input  logic [RPC-1:0][31:0] k_in,
  output logic [7:0][31:0]     st_out
);
  import sighash_stream_hasher_pkg::*;

  logic [7:0][31:0] s;
  logic [7:0][31:0] ns;
  logic [31:0]      t1;
  logic [31:0]      t2;

  // Index 0 is a, index 7 is h.
  always_comb begin
    s  = st_in;
    ns = '0;
    t1 = '0;
    t2 = '0;
    for (int r = 0; r < RPC; r++) begin
      t1    = s[7] + bsig1(s[4]) + ch(s[4], s[5], s[6]) + k_in[r] + w_in[r];
      t2    = bsig0(s[0]) + maj(s[0], s[1], s[2]);
      ns[0] = t1 + t2;
      ns[1] = s[0];
      ns[2] = s[1];
      ns[3] = s[2];
      ns[4] = s[3] + t1;
      ns[5] = s[4];
      ns[6] = s[5];
      ns[7] = s[6];
      s     = ns;
    end
    st_out = s;
  end

endmodule

// File: rtl/sighash_stream_hasher.sv
// Streaming SHA-256 / SHA256d engine: pads a run-time-length message internally and
// iterates one compression datapath over every block, with an optional second pass.
module sighash_stream_hasher #(
  parameter int LEN_W = 16,
  parameter int RPC   = 1
) (
  input logic                  clk,
  input logic                  rst,
  sighash_stream_hasher_if.slave bus
);
  import sighash_stream_hasher_pkg::*;

  localparam int         CYC      = 64 / RPC;
  localparam logic [5:0] LAST_RND = 6'(CYC - 1);
  localparam int         LPAD     = 64 - LEN_W - 3;

  state_t            state_q, state_d;
  logic [7:0][31:0]  h_q, h_d, wv_q, wv_d, wv_next;
  logic [15:0][31:0] w_q, w_d, ring;
  logic [LEN_W-1:0]  len_q, len_d, gi_q, gi_d, blk_q, blk_d;
  logic              dbl_q, dbl_d, second_q, second_d;
  logic [3:0]        wi_q, wi_d;
  logic [5:0]        rnd_q, rnd_d, t_idx;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [255:0]      digest_q, digest_d;

  logic [LEN_W+1:0]     len_ext, base, byte_idx;
  logic [63:0]          len_bits;
  logic                 msg_slot, word_ok;
  logic [31:0]          pad_word, w_new;
  logic [RPC-1:0][31:0] sched_w, sched_k;

  assign len_ext  = {2'b00, len_q};
  assign base     = {gi_q, 2'b00};
  assign len_bits = {{LPAD{1'b0}}, len_q, 3'b000};

  // Byte lanes at or past L become 0x80 then zeros; the final block ends in L*8.
  always_comb begin
    pad_word = '0;
    byte_idx = '0;
    msg_slot = base < len_ext;
    word_ok  = !msg_slot || bus.in_valid;
    for (int k = 0; k < 4; k++) begin
      byte_idx = base + (LEN_W+2)'(k);
      if (byte_idx < len_ext)       pad_word[31-8*k -: 8] = bus.in_data[31-8*k -: 8];
      else if (byte_idx == len_ext) pad_word[31-8*k -: 8] = 8'h80;
    end
    if (blk_q == LEN_W'(1) && wi_q == 4'd14)      pad_word = len_bits[63:32];
    else if (blk_q == LEN_W'(1) && wi_q == 4'd15) pad_word = len_bits[31:0];
  end

  // Ring slot 0 is always W[t]; each round shifts in W[t+16].
  always_comb begin
    ring    = w_q;
    sched_w = '0;
    sched_k = '0;
    t_idx   = '0;
    w_new   = '0;
    for (int r = 0; r < RPC; r++) begin
      t_idx      = 6'(int'(rnd_q) * RPC + r);
      sched_w[r] = ring[0];
      sched_k[r] = K[t_idx];
      w_new      = ssig1(ring[14]) + ring[9] + ssig0(ring[1]) + ring[0];
      ring       = {w_new, ring[15:1]};
    end
  end

  sighash_stream_hasher_round_core #(.RPC(RPC)) u_round_core (
    .st_in  (wv_q),
    .w_in   (sched_w),
    .k_in   (sched_k),
    .st_out (wv_next)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    wv_d      = wv_q;
    w_d       = w_q;
    len_d     = len_q;
    gi_d      = gi_q;
    blk_d     = blk_q;
    dbl_d     = dbl_q;
    second_d  = second_q;
    wi_d      = wi_q;
    rnd_d     = rnd_q;
    digest_d  = digest_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_LOAD;
          h_d      = H0;
          len_d    = bus.msg_len;
          dbl_d    = bus.dbl;
          second_d = 1'b0;
          gi_d     = '0;
          wi_d     = '0;
          blk_d    = LEN_W'(({1'b0, bus.msg_len} + (LEN_W+1)'(72)) >> 6);
        end
      end
      S_LOAD: begin
        if (word_ok) begin
          w_d  = {pad_word, w_q[15:1]};
          gi_d = gi_q + LEN_W'(1);
          wi_d = wi_q + 4'd1;
          if (wi_q == 4'd15) begin
            state_d = S_COMPRESS;
            rnd_d   = '0;
            wv_d    = h_q;
          end
        end
      end
      S_COMPRESS: begin
        w_d   = ring;
        wv_d  = wv_next;
        rnd_d = rnd_q + 6'd1;
        if (rnd_q == LAST_RND) state_d = S_FEED;
      end
      S_FEED: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        if (blk_q != LEN_W'(1)) begin
          blk_d   = blk_q - LEN_W'(1);
          wi_d    = '0;
          state_d = S_LOAD;
        end else if (dbl_q && !second_q) begin
          state_d = S_SECOND;
        end else begin
          state_d = S_DONE;
          for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = h_d[i];
        end
      end
      S_SECOND: begin
        for (int i = 0; i < 8; i++) w_d[i] = h_q[i];
        for (int i = 9; i < 15; i++) w_d[i] = '0;
        w_d[8]   = 32'h80000000;
        w_d[15]  = 32'h00000100;
        h_d      = H0;
        wv_d     = H0;
        second_d = 1'b1;
        rnd_d    = '0;
        state_d  = S_COMPRESS;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_LOAD) && ({gi_d, 2'b00} < {2'b00, len_d});
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      wv_q        <= '0;
      w_q         <= '0;
      len_q       <= '0;
      gi_q        <= '0;
      blk_q       <= '0;
      dbl_q       <= 1'b0;
      second_q    <= 1'b0;
      wi_q        <= '0;
      rnd_q       <= '0;
      digest_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      wv_q        <= wv_d;
      w_q         <= w_d;
      len_q       <= len_d;
      gi_q        <= gi_d;
      blk_q       <= blk_d;
      dbl_q       <= dbl_d;
      second_q    <= second_d;
      wi_q        <= wi_d;
      rnd_q       <= rnd_d;
      digest_q    <= digest_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_digest = digest_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sighash_stream_hasher.sv
// Directed scoreboard bench: runs the same job sequence on RPC=1, 2 and 4 engines
// and compares digests, latency, word consumption and handshake behaviour.
module tb_sighash_stream_hasher;

  localparam int LEN_W = 16;

  localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTYD = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
  localparam logic [255:0] D_56     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2:0]       start_v    = '0;
  logic [2:0]       dbl_v      = '0;
  logic [2:0]       in_valid_v = '0;
  logic [2:0]       out_ready_v = '0;
  logic [LEN_W-1:0] len_v [3];
  logic [31:0]      data_v [3];
  logic [2:0]       in_ready_v, out_valid_v, busy_v;
  logic [255:0]     digest_v [3];

  logic [31:0]  msg_words [$];
  logic [255:0] exp_q [$];
  logic [31:0]  abc56 [14] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
  };

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sighash_stream_hasher_if #(.LEN_W(LEN_W)) ifc ();
    assign ifc.start     = start_v[g];
    assign ifc.msg_len   = len_v[g];
    assign ifc.dbl       = dbl_v[g];
    assign ifc.in_valid  = in_valid_v[g];
    assign ifc.in_data   = data_v[g];
    assign ifc.out_ready = out_ready_v[g];
    assign in_ready_v[g]  = ifc.in_ready;
    assign out_valid_v[g] = ifc.out_valid;
    assign busy_v[g]      = ifc.busy;
    assign digest_v[g]    = ifc.out_digest;

    sighash_stream_hasher #(.LEN_W(LEN_W), .RPC(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Starts a job, streams msg_words whenever in_ready is high, and scores the digest.
  task automatic applyStimulus(input int sel, input string tag, input logic [LEN_W-1:0] len,
                               input logic dbl, input logic gaps, input int exp_lat,
                               input logic [255:0] exp_digest);
    int cyc, idx, consumed, stalls;
    logic rdy;
    logic [255:0] exp_d;
    exp_q.push_back(exp_digest);
    start_v[sel] = 1'b1;
    len_v[sel]   = len;
    dbl_v[sel]   = dbl;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    cyc = 0; idx = 0; consumed = 0; stalls = 0;
    while (out_valid_v[sel] !== 1'b1 && cyc < 2000) begin
      rdy = in_ready_v[sel];
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid_v[sel] = 1'b0;
      end else begin
        in_valid_v[sel] = 1'b1;
        data_v[sel] = (idx < msg_words.size()) ? msg_words[idx] : 32'hDEADBEEF;
      end
      if (rdy && !in_valid_v[sel]) stalls++;
      @(posedge clk); #1;
      if (rdy && in_valid_v[sel]) begin
        consumed++;
        idx++;
      end
      cyc++;
    end
    in_valid_v[sel] = 1'b0;
    checkOutput({tag, " out_valid"}, 256'(out_valid_v[sel]), 256'(1));
    if (exp_lat >= 0) checkOutput({tag, " latency"}, 256'(cyc), 256'(exp_lat + stalls));
    checkOutput({tag, " words"}, 256'(consumed), 256'(msg_words.size()));
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checkOutput({tag, " digest"}, digest_v[sel], exp_d);
  endtask

  // Holds the digest for `hold` cycles (pulsing a stray start), then completes the handshake.
  task automatic finishJob(input int sel, input string tag, input int hold, input logic [255:0] exp_digest);
    out_ready_v[sel] = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (i == 4) begin
        start_v[sel] = 1'b1;
        len_v[sel]   = 16'd3;
        dbl_v[sel]   = 1'b1;
      end else begin
        start_v[sel] = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput({tag, " hold digest"}, digest_v[sel], exp_digest);
      checkOutput({tag, " hold busy"}, 256'(busy_v[sel]), 256'(1));
      checkOutput({tag, " hold valid"}, 256'(out_valid_v[sel]), 256'(1));
    end
    start_v[sel]     = 1'b0;
    out_ready_v[sel] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[sel] = 1'b0;
    checkOutput({tag, " release busy"}, 256'(busy_v[sel]), 256'(0));
    checkOutput({tag, " release valid"}, 256'(out_valid_v[sel]), 256'(0));
    @(posedge clk); #1;
    checkOutput({tag, " idle busy"}, 256'(busy_v[sel]), 256'(0));
  endtask

  initial begin
    int blk;
    string rt;
    for (int s = 0; s < 3; s++) begin
      len_v[s]  = '0;
      data_v[s] = '0;
    end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("reset busy%0d", s), 256'(busy_v[s]), 256'(0));
      checkOutput($sformatf("reset in_ready%0d", s), 256'(in_ready_v[s]), 256'(0));
      checkOutput($sformatf("reset out_valid%0d", s), 256'(out_valid_v[s]), 256'(0));
      checkOutput($sformatf("reset digest%0d", s), digest_v[s], 256'(0));
    end

    for (int sel = 0; sel < 3; sel++) begin
      blk = 17 + (64 >> sel);
      rt  = $sformatf("rpc%0d", 1 << sel);
      $display("[TB] running %s", rt);

      msg_words.delete();
      applyStimulus(sel, {rt, " empty"}, 16'd0, 1'b0, 1'b0, blk, D_EMPTY);
      finishJob(sel, {rt, " empty"}, 10, D_EMPTY);

      msg_words.delete();
      msg_words.push_back(32'h616263A5);
      applyStimulus(sel, {rt, " abc"}, 16'd3, 1'b0, 1'b0, blk, D_ABC);
      finishJob(sel, {rt, " abc"}, 0, D_ABC);

      msg_words.delete();
      applyStimulus(sel, {rt, " empty dbl"}, 16'd0, 1'b1, 1'b0, -1, D_EMPTYD);
      finishJob(sel, {rt, " empty dbl"}, 0, D_EMPTYD);

      msg_words.delete();
      for (int i = 0; i < 14; i++) msg_words.push_back(abc56[i]);
      applyStimulus(sel, {rt, " msg56"}, 16'd56, 1'b0, 1'b1, 2 * blk, D_56);
      finishJob(sel, {rt, " msg56"}, 0, D_56);

      start_v[sel] = 1'b1;
      len_v[sel]   = 16'd0;
      dbl_v[sel]   = 1'b0;
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput({rt, " midjob busy"}, 256'(busy_v[sel]), 256'(1));
      rst = 1'b1;
      #1;
      checkOutput({rt, " abort busy"}, 256'(busy_v[sel]), 256'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput({rt, " abort valid"}, 256'(out_valid_v[sel]), 256'(0));
      checkOutput({rt, " abort in_ready"}, 256'(in_ready_v[sel]), 256'(0));
      checkOutput({rt, " abort digest"}, digest_v[sel], 256'(0));

      msg_words.delete();
      msg_words.push_back(32'h61626377);
      applyStimulus(sel, {rt, " abc after reset"}, 16'd3, 1'b0, 1'b0, blk, D_ABC);
      finishJob(sel, {rt, " abc after reset"}, 0, D_ABC);
    end

    checkOutput("scoreboard drained", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
